// File: rtl/branch_predict_unit_pkg.sv
// Shared definitions for the branch predictor: control opcodes, 2-bit
// counter encodings, instruction decode and counter update helpers.
package branch_predict_unit_pkg;

   localparam logic [4:0] OP_J   = 5'b00001;
   localparam logic [4:0] OP_BNE = 5'b00010;
   localparam logic [4:0] OP_JAL = 5'b00011;
   localparam logic [4:0] OP_JR  = 5'b00100;
   localparam logic [4:0] OP_BLT = 5'b00110;
   localparam logic [4:0] OP_BEX = 5'b10110;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } cnt_t;

   typedef struct packed {
      logic ctrl;
      logic uncond;
      logic is_jr;
      logic is_bne;
      logic is_blt;
      logic is_bex;
   } ctrl_dec_t;

   function automatic ctrl_dec_t decode_op(input logic [4:0] op);
      ctrl_dec_t d;
      d = '0;
      case (op)
         OP_J, OP_JAL: d.uncond = 1'b1;
         OP_JR: begin
            d.uncond = 1'b1;
            d.is_jr  = 1'b1;
         end
         OP_BNE: d.is_bne = 1'b1;
         OP_BLT: d.is_blt = 1'b1;
         OP_BEX: d.is_bex = 1'b1;
         default: d = '0;
      endcase
      d.ctrl = d.uncond | d.is_bne | d.is_blt | d.is_bex;
      return d;
   endfunction

   // Saturating 2-bit counter step; unconditional jumps pin the counter strong-taken.
   function automatic cnt_t cnt_next(input cnt_t c, input logic taken, input logic force_st);
      cnt_t n;
      n = c;
      if (force_st) begin
         n = ST;
      end else begin
         case (c)
            SNT: n = taken ? WNT : SNT;
            WNT: n = taken ? WT  : SNT;
            WT:  n = taken ? ST  : WNT;
            ST:  n = taken ? ST  : WT;
            default: n = c;
         endcase
      end
      return n;
   endfunction

endpackage

// File: rtl/btb_entry.sv
// One branch target buffer entry: valid, tag, target and 2-bit counter,
// with its own hit detection for the execute-stage update.
module btb_entry
   import branch_predict_unit_pkg::*;
#(
   parameter int unsigned TAG_W = 28,
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             upd,
   input  logic             upd_taken,
   input  logic             upd_force,
   input  logic [TAG_W-1:0] upd_tag,
   input  logic [WIDTH-1:0] upd_target,
   output logic             valid,
   output logic [TAG_W-1:0] tag,
   output logic [WIDTH-1:0] target,
   output logic [1:0]       cnt
);

   cnt_t cnt_q;
   logic hit_c;

   assign hit_c = valid && (tag == upd_tag);
   assign cnt   = cnt_q;

   // Hits train the counter; misses only allocate on a taken outcome.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid  <= 1'b0;
         tag    <= '0;
         target <= '0;
         cnt_q  <= WNT;
      end else if (upd) begin
         if (hit_c) begin
            cnt_q <= cnt_next(cnt_q, upd_taken, upd_force);
            if (upd_taken) begin
               target <= upd_target;
            end
         end else if (upd_taken) begin
            valid  <= 1'b1;
            tag    <= upd_tag;
            target <= upd_target;
            cnt_q  <= upd_force ? ST : WT;
         end
      end
   end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB branch predictor: fetch-stage lookup, execute-stage
// resolution with flush/redirect, training and saturating statistics.
module branch_predict_unit
   import branch_predict_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] f_pc,
   input  logic [WIDTH-1:0] f_pc_next_def,
   output logic [WIDTH-1:0] f_pc_next,
   output logic             f_pred_taken,
   input  logic             x_valid,
   input  logic [WIDTH-1:0] x_pc,
   input  logic [WIDTH-1:0] x_pc_plus1,
   input  logic [31:0]      x_ir,
   input  logic [WIDTH-1:0] x_rd,
   input  logic             x_neq,
   input  logic             x_lt,
   input  logic             x_pred_taken,
   input  logic [WIDTH-1:0] x_pred_target,
   output logic             flush,
   output logic [WIDTH-1:0] redirect_pc,
   output logic [CNT_W-1:0] stat_branches,
   output logic [CNT_W-1:0] stat_mispredicts
);

   localparam int unsigned IDX   = $clog2(DEPTH);
   localparam int unsigned TAG_W = WIDTH - IDX;

   logic             e_valid  [DEPTH];
   logic [TAG_W-1:0] e_tag    [DEPTH];
   logic [WIDTH-1:0] e_target [DEPTH];
   logic [1:0]       e_cnt    [DEPTH];

   logic [IDX-1:0]   f_idx;
   logic [TAG_W-1:0] f_tag;
   logic [IDX-1:0]   x_idx;
   logic [TAG_W-1:0] x_tag;

   ctrl_dec_t        dec;
   logic             rd_nz_c;
   logic             taken_c;
   logic [WIDTH-1:0] target_c;
   logic             upd_en_c;
   logic             hit_c;
   logic             pred_c;
   logic             mispredict_c;

   assign f_idx = f_pc[IDX-1:0];
   assign f_tag = f_pc[WIDTH-1:IDX];
   assign x_idx = x_pc[IDX-1:0];
   assign x_tag = x_pc[WIDTH-1:IDX];

   assign dec      = decode_op(x_ir[31:27]);
   assign rd_nz_c  = (x_rd != '0);
   assign upd_en_c = x_valid && dec.ctrl;

   for (genvar i = 0; i < DEPTH; i++) begin : g_btb
      logic upd_sel;
      assign upd_sel = upd_en_c && (x_idx == IDX'(i));

      btb_entry #(
         .TAG_W (TAG_W),
         .WIDTH (WIDTH)
      ) u_entry (
         .clock      (clock),
         .reset      (reset),
         .upd        (upd_sel),
         .upd_taken  (taken_c),
         .upd_force  (dec.uncond),
         .upd_tag    (x_tag),
         .upd_target (target_c),
         .valid      (e_valid[i]),
         .tag        (e_tag[i]),
         .target     (e_target[i]),
         .cnt        (e_cnt[i])
      );
   end

   // Resolve actual outcome and target of the execute-stage instruction.
   always_comb begin
      taken_c  = dec.uncond
               | (dec.is_bne & x_neq)
               | (dec.is_blt & x_lt)
               | (dec.is_bex & rd_nz_c);
      target_c = {{(WIDTH-27){1'b0}}, x_ir[26:0]};
      if (dec.is_bne || dec.is_blt) begin
         target_c = x_pc_plus1 + {{(WIDTH-17){x_ir[16]}}, x_ir[16:0]};
      end else if (dec.is_jr) begin
         target_c = x_rd;
      end
   end

   // Lookup sees pre-update contents; execute redirect wins over fetch prediction.
   always_comb begin
      hit_c        = e_valid[f_idx] && (e_tag[f_idx] == f_tag);
      pred_c       = hit_c && e_cnt[f_idx][1];
      mispredict_c = x_valid && ((taken_c != x_pred_taken) ||
                                 (taken_c && x_pred_taken && (target_c != x_pred_target)));
      flush        = mispredict_c && !reset;
      redirect_pc  = taken_c ? target_c : x_pc_plus1;
      f_pred_taken = pred_c && !reset;
      f_pc_next    = f_pc_next_def;
      if (flush) begin
         f_pc_next = redirect_pc;
      end else if (f_pred_taken) begin
         f_pc_next = e_target[f_idx];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else begin
         if (upd_en_c && (stat_branches != '1)) begin
            stat_branches <= stat_branches + CNT_W'(1);
         end
         if (flush && (stat_mispredicts != '1)) begin
            stat_mispredicts <= stat_mispredicts + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed scoreboard bench for branch_predict_unit (default counters plus a
// 2-bit statistics instance for saturation).
module tb_branch_predict_unit;

   localparam int unsigned WIDTH = 32;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } sb_t;

   logic             clock;
   logic             reset;
   logic [WIDTH-1:0] f_pc, f_pc_next_def;
   logic             x_valid, x_neq, x_lt, x_pred_taken;
   logic [WIDTH-1:0] x_pc, x_pc_plus1, x_rd, x_pred_target;
   logic [31:0]      x_ir;

   logic [WIDTH-1:0] f_pc_next, redirect_pc;
   logic             f_pred_taken, flush;
   logic [15:0]      stat_branches, stat_mispredicts;

   logic [WIDTH-1:0] f_pc_next2, redirect_pc2;
   logic             f_pred_taken2, flush2;
   logic [1:0]       stat_branches2, stat_mispredicts2;

   sb_t sb[$];
   int  n_vec = 0;
   int  n_err = 0;
   int  m_br  = 0;
   int  m_mp  = 0;

   branch_predict_unit #(.WIDTH(32), .DEPTH(16), .CNT_W(16)) dut (
      .clock(clock), .reset(reset), .f_pc(f_pc), .f_pc_next_def(f_pc_next_def),
      .f_pc_next(f_pc_next), .f_pred_taken(f_pred_taken), .x_valid(x_valid),
      .x_pc(x_pc), .x_pc_plus1(x_pc_plus1), .x_ir(x_ir), .x_rd(x_rd),
      .x_neq(x_neq), .x_lt(x_lt), .x_pred_taken(x_pred_taken),
      .x_pred_target(x_pred_target), .flush(flush), .redirect_pc(redirect_pc),
      .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
   );

   branch_predict_unit #(.WIDTH(32), .DEPTH(16), .CNT_W(2)) dut2 (
      .clock(clock), .reset(reset), .f_pc(f_pc), .f_pc_next_def(f_pc_next_def),
      .f_pc_next(f_pc_next2), .f_pred_taken(f_pred_taken2), .x_valid(x_valid),
      .x_pc(x_pc), .x_pc_plus1(x_pc_plus1), .x_ir(x_ir), .x_rd(x_rd),
      .x_neq(x_neq), .x_lt(x_lt), .x_pred_taken(x_pred_taken),
      .x_pred_target(x_pred_target), .flush(flush2), .redirect_pc(redirect_pc2),
      .stat_branches(stat_branches2), .stat_mispredicts(stat_mispredicts2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [26:0] field);
      return {op, field};
   endfunction

   task automatic push(input string t, input logic [31:0] e);
      sb_t it;
      it.tag = t;
      it.exp = e;
      sb.push_back(it);
   endtask

   task automatic pop_chk(input logic [31:0] obs);
      sb_t it;
      n_vec++;
      if (sb.size() == 0) begin
         n_err++;
         $error("FAIL scoreboard_empty observed=%h expected=none", obs);
      end else begin
         it = sb.pop_front();
         assert (obs === it.exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", it.tag, obs, it.exp);
         end
      end
   endtask

   task automatic fdrive(input logic [31:0] pc, input logic [31:0] def);
      f_pc          = pc;
      f_pc_next_def = def;
   endtask

   task automatic xdrive(input logic v, input logic [31:0] ir, input logic [31:0] pc,
                         input logic [31:0] rd, input logic neq, input logic lt,
                         input logic pt, input logic [31:0] ptgt);
      x_valid       = v;
      x_ir          = ir;
      x_pc          = pc;
      x_pc_plus1    = pc + 32'd1;
      x_rd          = rd;
      x_neq         = neq;
      x_lt          = lt;
      x_pred_taken  = pt;
      x_pred_target = ptgt;
   endtask

   task automatic idle();
      xdrive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   // Check combinational outputs mid-cycle, then clock and advance the stats model.
   task automatic step(input string nm, input logic ef, input logic [31:0] er,
                       input logic ep, input logic [31:0] en, input logic ctrl);
      push({nm, "_flush"}, 32'(ef));
      push({nm, "_flush2"}, 32'(ef));
      if (x_valid) push({nm, "_redirect"}, er);
      push({nm, "_pred"}, 32'(ep));
      push({nm, "_next"}, en);
      #3;
      pop_chk(32'(flush));
      pop_chk(32'(flush2));
      if (x_valid) pop_chk(redirect_pc);
      pop_chk(32'(f_pred_taken));
      pop_chk(f_pc_next);
      @(posedge clock);
      #1;
      if (!reset) begin
         if (x_valid && ctrl) m_br++;
         if (x_valid && ef) m_mp++;
      end
   endtask

   task automatic check_stats(input string nm);
      push({nm, "_br"},  32'(m_br));
      push({nm, "_mp"},  32'(m_mp));
      push({nm, "_br2"}, 32'((m_br > 3) ? 3 : m_br));
      push({nm, "_mp2"}, 32'((m_mp > 3) ? 3 : m_mp));
      pop_chk(32'(stat_branches));
      pop_chk(32'(stat_mispredicts));
      pop_chk(32'(stat_branches2));
      pop_chk(32'(stat_mispredicts2));
   endtask

   initial begin
      reset = 1'b1;
      fdrive(32'h20, 32'h21);
      idle();
      repeat (2) @(posedge clock);
      #1;

      // Outputs gated while reset is held, even with a mispredicting branch present.
      xdrive(1'b1, mk_ir(5'b00010, 27'd5), 32'h20, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
      step("in_reset", 1'b0, 32'h26, 1'b0, 32'h21, 1'b1);
      check_stats("reset");

      reset = 1'b0;
      idle();
      step("post_reset", 1'b0, 32'h0, 1'b0, 32'h21, 1'b0);

      xdrive(1'b1, mk_ir(5'b00010, 27'd5), 32'h20, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
      step("bne_taken", 1'b1, 32'h26, 1'b0, 32'h26, 1'b1);
      idle();
      step("bne_alloc", 1'b0, 32'h0, 1'b1, 32'h26, 1'b0);

      xdrive(1'b1, mk_ir(5'b00010, 27'd5), 32'h20, 32'h0, 1'b0, 1'b0, 1'b1, 32'h26);
      step("bne_nt1", 1'b1, 32'h21, 1'b1, 32'h21, 1'b1);
      step("bne_nt2", 1'b1, 32'h21, 1'b0, 32'h21, 1'b1);
      idle();
      step("bne_cold", 1'b0, 32'h0, 1'b0, 32'h21, 1'b0);
      check_stats("after_bne");

      fdrive(32'h33, 32'h34);
      xdrive(1'b1, mk_ir(5'b00100, 27'd0), 32'h33, 32'h1234, 1'b0, 1'b0, 1'b1, 32'h1000);
      step("jr_bad_tgt", 1'b1, 32'h1234, 1'b0, 32'h1234, 1'b1);
      check_stats("sat");
      idle();
      step("jr_strong", 1'b0, 32'h0, 1'b1, 32'h1234, 1'b0);

      fdrive(32'h45, 32'h46);
      xdrive(1'b1, mk_ir(5'b10110, 27'h40), 32'h45, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      step("bex_zero", 1'b0, 32'h46, 1'b0, 32'h46, 1'b1);
      xdrive(1'b1, mk_ir(5'b10110, 27'h40), 32'h45, 32'h7, 1'b0, 1'b0, 1'b1, 32'h40);
      step("bex_taken", 1'b0, 32'h40, 1'b0, 32'h46, 1'b1);
      idle();
      step("bex_alloc", 1'b0, 32'h0, 1'b1, 32'h40, 1'b0);

      fdrive(32'h20, 32'h21);
      xdrive(1'b1, 32'h0, 32'h67, 32'h0, 1'b1, 1'b1, 1'b1, 32'h70);
      step("nonctrl", 1'b1, 32'h68, 1'b0, 32'h68, 1'b0);

      fdrive(32'h120, 32'h121);
      xdrive(1'b1, mk_ir(5'b00110, {10'b0, 17'h1FFFD}), 32'h109, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
      step("blt_neg", 1'b1, 32'h107, 1'b0, 32'h107, 1'b1);
      idle();
      fdrive(32'h109, 32'h10A);
      step("blt_alloc", 1'b0, 32'h0, 1'b1, 32'h107, 1'b0);
      fdrive(32'h133, 32'h134);
      step("alias_miss", 1'b0, 32'h0, 1'b0, 32'h134, 1'b0);
      check_stats("pre_async");

      // Reset pulse between clock edges must clear state immediately.
      #1 reset = 1'b1;
      #1;
      m_br = 0;
      m_mp = 0;
      check_stats("async_reset");
      #1 reset = 1'b0;
      fdrive(32'h33, 32'h34);
      step("after_async", 1'b0, 32'h0, 1'b0, 32'h34, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
